datamem_mapped: RTL and testbench

- Parametrised, single-port, word-addressed data memory for the uPx CPU.
- Generalises the fixed 8-bit datamem:
  - configurable width and depth;
  - configurable count of memory-mapped pointer pairs;
  - auto-increment/decrement on the selected pointer;
  - registered read with a valid strobe;
  - hardware zero-scrub after reset.
- ALU result and ALU flag words are memory-mapped and writable by the ALU.
- The selected pointer pair drives the system address bus.

---
 rtl/datamem_mapped_if.sv | 38 +++
 rtl/datamem_mapped.sv | 164 ++++++++++++++++
 tb/tb_datamem_mapped.sv | 245 ++++++++++++++++++++++++
 3 files changed

// File: rtl/datamem_mapped_if.sv
// Bus bundle between the uPx CPU/ALU side and datamem_mapped.
//   master : drives addr/wdata/wr/rd, ALU capture inputs and pointer control;
//            receives rdata/rvalid/ready/addbus.
//   slave  : the memory side (datamem_mapped).
interface datamem_mapped_if #(
  parameter int DW   = 8,
  parameter int AW   = 10,
  parameter int NPTR = 3
);
  localparam int PSW = (NPTR > 1) ? $clog2(NPTR) : 1;

  logic [AW-1:0]   addr;
  logic [DW-1:0]   wdata;
  logic            wr;
  logic            rd;
  logic [DW-1:0]   rdata;
  logic            rvalid;
  logic            ready;
  logic [DW-1:0]   alu_out;
  logic [DW-1:0]   alu_flag;
  logic            alu_write;
  logic [PSW-1:0]  ptr_sel;
  logic            ptr_inc;
  logic            ptr_dec;
  logic [2*DW-1:0] addbus;

  modport master (
    output addr, wdata, wr, rd, alu_out, alu_flag, alu_write,
           ptr_sel, ptr_inc, ptr_dec,
    input  rdata, rvalid, ready, addbus
  );

  modport slave (
    input  addr, wdata, wr, rd, alu_out, alu_flag, alu_write,
           ptr_sel, ptr_inc, ptr_dec,
    output rdata, rvalid, ready, addbus
  );
endinterface

// File: rtl/datamem_mapped.sv
// Word-addressed data memory for the uPx CPU with memory-mapped ALU result/flag
// words and NPTR pointer pairs that can auto-increment/decrement and drive the
// system address bus. After reset the whole RAM is zero-scrubbed (ready low).
// Ports:
//   clk  : system clock, rising edge
//   clr  : asynchronous active-high reset
//   bus  : datamem_mapped_if.slave (CPU strobes, read data/valid, ready,
//          ALU capture, pointer select/modify, addbus)
module datamem_mapped #(
  parameter int DW            = 8,
  parameter int AW            = 10,
  parameter int NPTR          = 3,
  parameter int PTR_BASE      = 26,
  parameter int ALU_OUT_ADDR  = 2,
  parameter int ALU_FLAG_ADDR = 32
) (
  input  logic clk,
  input  logic clr,
  datamem_mapped_if.slave bus
);

  localparam int DEPTH = 2**AW;
  localparam logic [2*DW-1:0] PAIR_ONE = 1;

  typedef enum logic {SCRUB, IDLE} state_t;

  state_t          state_q, state_d;
  logic [AW-1:0]   cnt_q, cnt_d;
  logic [DW-1:0]   mem_q [DEPTH];
  logic [DW-1:0]   rdata_q, rdata_d;
  logic            rvalid_q, rvalid_d;
  logic [DW-1:0]   alu_out_q, alu_out_d;
  logic [DW-1:0]   alu_flag_q, alu_flag_d;
  logic [DW-1:0]   ptr_lo_q [NPTR];
  logic [DW-1:0]   ptr_lo_d [NPTR];
  logic [DW-1:0]   ptr_hi_q [NPTR];
  logic [DW-1:0]   ptr_hi_d [NPTR];

  logic            ready;
  logic            wr_ok, rd_ok, mod_ok;
  logic            wr_lo, wr_hi;
  logic [DW-1:0]   rd_val;
  logic [2*DW-1:0] pair;
  logic [2*DW-1:0] addbus;
  logic            mem_we;
  logic [AW-1:0]   mem_wa;
  logic [DW-1:0]   mem_wd;

  assign ready  = (state_q == IDLE);
  assign wr_ok  = ready && bus.wr;
  assign rd_ok  = ready && bus.rd;
  // inc and dec together cancel out
  assign mod_ok = ready && (bus.ptr_inc ^ bus.ptr_dec);

  // Scrub sequencer
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      SCRUB: begin
        cnt_d = cnt_q + AW'(1);
        if (cnt_q == AW'(DEPTH-1)) state_d = IDLE;
      end
      default: ;
    endcase
  end

  // Single RAM write port shared by the scrubber and the CPU
  always_comb begin
    mem_we = 1'b0;
    mem_wa = cnt_q;
    mem_wd = '0;
    if (!ready) begin
      mem_we = 1'b1;
    end else if (bus.wr) begin
      mem_we = 1'b1;
      mem_wa = bus.addr;
      mem_wd = bus.wdata;
    end
  end

  always_ff @(posedge clk) begin
    if (mem_we) mem_q[mem_wa] <= mem_wd;
  end

  // Read mux over RAM and mapped flops; next state of mapped flops
  always_comb begin
    rd_val = mem_q[bus.addr];
    if (bus.addr == AW'(ALU_OUT_ADDR))  rd_val = alu_out_q;
    if (bus.addr == AW'(ALU_FLAG_ADDR)) rd_val = alu_flag_q;

    alu_out_d  = alu_out_q;
    alu_flag_d = alu_flag_q;
    if (wr_ok && bus.addr == AW'(ALU_OUT_ADDR))  alu_out_d  = bus.wdata;
    if (wr_ok && bus.addr == AW'(ALU_FLAG_ADDR)) alu_flag_d = bus.wdata;
    // ALU capture overrides a same-cycle CPU write
    if (ready && bus.alu_write) begin
      alu_out_d  = bus.alu_out;
      alu_flag_d = bus.alu_flag;
    end

    pair  = '0;
    wr_lo = 1'b0;
    wr_hi = 1'b0;
    for (int k = 0; k < NPTR; k++) begin
      wr_lo = wr_ok && (bus.addr == AW'(PTR_BASE + 2*k));
      wr_hi = wr_ok && (bus.addr == AW'(PTR_BASE + 2*k + 1));
      if (bus.addr == AW'(PTR_BASE + 2*k))     rd_val = ptr_lo_q[k];
      if (bus.addr == AW'(PTR_BASE + 2*k + 1)) rd_val = ptr_hi_q[k];
      pair = {ptr_hi_q[k], ptr_lo_q[k]};
      // A CPU write to either byte of the pair suppresses the modify
      if (mod_ok && (int'(bus.ptr_sel) == k) && !(wr_lo || wr_hi)) begin
        if (bus.ptr_inc) pair = pair + PAIR_ONE;
        else             pair = pair - PAIR_ONE;
      end
      ptr_lo_d[k] = wr_lo ? bus.wdata : pair[DW-1:0];
      ptr_hi_d[k] = wr_hi ? bus.wdata : pair[2*DW-1:DW];
    end
  end

  always_comb begin
    addbus = '0;
    if (ready) begin
      for (int k = 0; k < NPTR; k++) begin
        if (int'(bus.ptr_sel) == k) addbus = {ptr_hi_q[k], ptr_lo_q[k]};
      end
    end
  end

  assign rvalid_d = rd_ok;
  assign rdata_d  = rd_ok ? rd_val : rdata_q;

  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      state_q    <= SCRUB;
      cnt_q      <= '0;
      rdata_q    <= '0;
      rvalid_q   <= 1'b0;
      alu_out_q  <= '0;
      alu_flag_q <= '0;
      for (int k = 0; k < NPTR; k++) begin
        ptr_lo_q[k] <= '0;
        ptr_hi_q[k] <= '0;
      end
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      rdata_q    <= rdata_d;
      rvalid_q   <= rvalid_d;
      alu_out_q  <= alu_out_d;
      alu_flag_q <= alu_flag_d;
      for (int k = 0; k < NPTR; k++) begin
        ptr_lo_q[k] <= ptr_lo_d[k];
        ptr_hi_q[k] <= ptr_hi_d[k];
      end
    end
  end

  assign bus.rdata  = rdata_q;
  assign bus.rvalid = rvalid_q;
  assign bus.ready  = ready;
  assign bus.addbus = addbus;

endmodule

// File: tb/tb_datamem_mapped.sv
// Directed bench for datamem_mapped: read expectations are queued when rd is
// driven and popped when the read completes.
module tb_datamem_mapped;

  logic clk = 1'b0;
  logic clr;
  logic tb_ready;
  int   passed = 0;
  int   failed = 0;
  int   total  = 0;
  logic [7:0] exp_q [$];

  always #5 clk = ~clk;

  datamem_mapped_if #(.DW(8), .AW(10), .NPTR(3)) bus ();

  datamem_mapped #(
    .DW(8), .AW(10), .NPTR(3), .PTR_BASE(26),
    .ALU_OUT_ADDR(2), .ALU_FLAG_ADDR(32)
  ) dut (
    .clk (clk),
    .clr (clr),
    .bus (bus)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else begin
      failed++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    logic       e;
    logic [7:0] x;
    e = bus.rd && tb_ready;
    @(posedge clk);
    #1;
    if (e || bus.rvalid) chk("rvalid", bus.rvalid, e);
    if (e && exp_q.size() > 0) begin
      x = exp_q.pop_front();
      chk("rdata", bus.rdata, x);
    end
  endtask

  task automatic wr_word(input logic [9:0] a, input logic [7:0] d);
    bus.addr  = a;
    bus.wdata = d;
    bus.wr    = 1'b1;
    tick();
    bus.wr    = 1'b0;
  endtask

  task automatic rd_word(input logic [9:0] a, input logic [7:0] e);
    bus.addr = a;
    bus.rd   = 1'b1;
    exp_q.push_back(e);
    tick();
    bus.rd   = 1'b0;
  endtask

  task automatic wait_ready(input int already, input string tag);
    int n;
    n = already;
    while (bus.ready !== 1'b1 && n < 2000) begin
      tick();
      n++;
    end
    chk(tag, n, 1024);
    tb_ready = 1'b1;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    clr           = 1'b1;
    tb_ready      = 1'b0;
    bus.addr      = '0;
    bus.wdata     = '0;
    bus.wr        = 1'b0;
    bus.rd        = 1'b0;
    bus.alu_out   = '0;
    bus.alu_flag  = '0;
    bus.alu_write = 1'b0;
    bus.ptr_sel   = '0;
    bus.ptr_inc   = 1'b0;
    bus.ptr_dec   = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_ready", bus.ready, 0);
    chk("rst_rvalid", bus.rvalid, 0);
    chk("rst_rdata", bus.rdata, 0);
    chk("rst_addbus", bus.addbus, 0);

    // Strobes during scrub must be ignored
    clr         = 1'b0;
    bus.rd      = 1'b1;
    bus.wr      = 1'b1;
    bus.addr    = 10'd5;
    bus.wdata   = 8'h77;
    bus.ptr_inc = 1'b1;
    tick();
    bus.rd      = 1'b0;
    bus.wr      = 1'b0;
    bus.ptr_inc = 1'b0;
    chk("scrub_addbus", bus.addbus, 0);
    chk("scrub_ready", bus.ready, 0);
    wait_ready(1, "scrub_len");

    rd_word(10'd0, 8'h00);
    rd_word(10'd511, 8'h00);
    rd_word(10'd1023, 8'h00);
    rd_word(10'd5, 8'h00);

    wr_word(10'd5, 8'hA5);
    rd_word(10'd5, 8'hA5);
    tick();
    chk("rvalid_single", bus.rvalid, 0);
    chk("rdata_hold", bus.rdata, 8'hA5);

    // Read-before-write on the same address
    bus.addr  = 10'd5;
    bus.wdata = 8'h3C;
    bus.wr    = 1'b1;
    bus.rd    = 1'b1;
    exp_q.push_back(8'hA5);
    tick();
    bus.wr    = 1'b0;
    bus.rd    = 1'b0;
    rd_word(10'd5, 8'h3C);

    // ALU capture beats a same-cycle CPU write
    bus.alu_out   = 8'h7E;
    bus.alu_flag  = 8'h01;
    bus.alu_write = 1'b1;
    bus.addr      = 10'd2;
    bus.wdata     = 8'hFF;
    bus.wr        = 1'b1;
    tick();
    bus.alu_write = 1'b0;
    bus.wr        = 1'b0;
    rd_word(10'd2, 8'h7E);
    rd_word(10'd32, 8'h01);
    wr_word(10'd32, 8'h5A);
    rd_word(10'd32, 8'h5A);

    // Pointer pair 1
    wr_word(10'd28, 8'hFF);
    wr_word(10'd29, 8'h00);
    bus.ptr_sel = 2'd1;
    #1;
    chk("p1_written", bus.addbus, 16'h00FF);
    bus.ptr_inc = 1'b1;
    tick();
    bus.ptr_inc = 1'b0;
    chk("p1_inc_carry", bus.addbus, 16'h0100);
    bus.ptr_dec = 1'b1;
    tick();
    tick();
    bus.ptr_dec = 1'b0;
    chk("p1_dec2", bus.addbus, 16'h00FE);
    rd_word(10'd28, 8'hFE);
    rd_word(10'd29, 8'h00);

    // Pointer pair 0 wrap, write suppresses modify, inc+dec cancel
    bus.ptr_sel = 2'd0;
    #1;
    chk("p0_zero", bus.addbus, 16'h0000);
    bus.ptr_dec = 1'b1;
    tick();
    bus.ptr_dec = 1'b0;
    chk("p0_wrap", bus.addbus, 16'hFFFF);
    wr_word(10'd27, 8'h00);
    chk("p0_hi_wr", bus.addbus, 16'h00FF);
    bus.ptr_inc = 1'b1;
    bus.addr    = 10'd26;
    bus.wdata   = 8'h10;
    bus.wr      = 1'b1;
    tick();
    bus.ptr_inc = 1'b0;
    bus.wr      = 1'b0;
    chk("p0_wr_suppress", bus.addbus, 16'h0010);
    bus.ptr_inc = 1'b1;
    bus.ptr_dec = 1'b1;
    tick();
    bus.ptr_inc = 1'b0;
    bus.ptr_dec = 1'b0;
    chk("p0_incdec", bus.addbus, 16'h0010);

    // Out-of-range select
    bus.ptr_sel = 2'd3;
    #1;
    chk("sel3_addbus", bus.addbus, 16'h0000);
    bus.ptr_inc = 1'b1;
    tick();
    bus.ptr_inc = 1'b0;
    chk("sel3_addbus2", bus.addbus, 16'h0000);
    bus.ptr_sel = 2'd1;
    #1;
    chk("sel3_p1", bus.addbus, 16'h00FE);
    bus.ptr_sel = 2'd0;
    #1;
    chk("sel3_p0", bus.addbus, 16'h0010);
    bus.ptr_sel = 2'd2;
    #1;
    chk("sel3_p2", bus.addbus, 16'h0000);

    // Reset mid-scrub restarts the full scrub
    wr_word(10'd100, 8'h55);
    clr      = 1'b1;
    tb_ready = 1'b0;
    tick();
    clr      = 1'b0;
    repeat (300) tick();
    chk("mid_scrub_ready", bus.ready, 0);
    clr = 1'b1;
    tick();
    tick();
    chk("restart_ready_clr", bus.ready, 0);
    clr = 1'b0;
    wait_ready(0, "scrub_restart_len");

    rd_word(10'd5, 8'h00);
    rd_word(10'd100, 8'h00);
    rd_word(10'd2, 8'h00);
    rd_word(10'd32, 8'h00);
    rd_word(10'd26, 8'h00);
    rd_word(10'd28, 8'h00);
    rd_word(10'd29, 8'h00);
    bus.ptr_sel = 2'd1;
    #1;
    chk("post_rst_addbus", bus.addbus, 16'h0000);
    chk("sb_drained", exp_q.size(), 0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
